// File: rtl/tiny_fpga_cfg_loader.sv
// tiny_fpga_cfg_loader
// Takes a framed byte stream (header, payload, XOR checksum). It shifts the
// payload LSB-first into the fabric configuration chain, then raises a single
// commit pulse, but only when the checksum byte matches the payload XOR.
// All outputs are registered. Each one comes from the next-state decode, so it
// tracks the state register cycle for cycle.

module tiny_fpga_cfg_loader #(
    parameter int          CFG_BITS = 64,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_mode,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       chain_bit,
    output logic       chain_shift,
    output logic       cfg_commit,
    output logic       cfg_done,
    output logic       cfg_error,
    output logic       busy
);

    localparam int NBYTES = CFG_BITS / 8;
    localparam int BCW    = $clog2(NBYTES + 1);
    localparam logic [BCW-1:0] NBYTES_C = BCW'(NBYTES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]     acc_q, acc_d;
    logic [7:0]     shreg_q, shreg_d;

    logic byte_ready_q, byte_ready_d;
    logic chain_bit_q, chain_bit_d;
    logic chain_shift_q, chain_shift_d;
    logic cfg_commit_q, cfg_commit_d;
    logic cfg_done_q, cfg_done_d;
    logic cfg_error_q, cfg_error_d;
    logic busy_q, busy_d;

    logic xfer_s;

    // A byte moves only when the registered ready flag and valid are both high
    assign xfer_s = byte_valid & byte_ready_q;

    // Next-state, datapath and counter update
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        acc_d      = acc_q;
        shreg_d    = shreg_q;

        if (!cfg_mode) begin
            // Abort wins over everything else; a partial byte is dropped
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_HDR;
                end
                ST_HDR: begin
                    byte_cnt_d = {BCW{1'b0}};
                    acc_d      = 8'h00;
                    if (xfer_s) begin
                        state_d = (byte_in == HEADER) ? ST_LOAD : ST_ERROR;
                    end else begin
                        state_d = ST_HDR;
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        shreg_d    = byte_in;
                        acc_d      = acc_q ^ byte_in;
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        bit_cnt_d  = 3'd0;
                        state_d    = ST_SHIFT;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_SHIFT: begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (byte_cnt_q == NBYTES_C) ? ST_CHK : ST_LOAD;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_CHK: begin
                    if (xfer_s) begin
                        state_d = (byte_in == acc_q) ? ST_DONE : ST_ERROR;
                    end else begin
                        state_d = ST_CHK;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so registered outputs line up with it
    always_comb begin
        byte_ready_d  = 1'b0;
        chain_shift_d = 1'b0;
        chain_bit_d   = 1'b0;
        cfg_commit_d  = 1'b0;
        cfg_done_d    = 1'b0;
        cfg_error_d   = 1'b0;
        busy_d        = 1'b0;
        case (state_d)
            ST_HDR, ST_LOAD, ST_CHK: begin
                byte_ready_d = 1'b1;
                busy_d       = 1'b1;
            end
            ST_SHIFT: begin
                chain_shift_d = 1'b1;
                chain_bit_d   = shreg_d[0];
                busy_d        = 1'b1;
            end
            ST_DONE: begin
                cfg_done_d   = 1'b1;
                cfg_commit_d = (state_q != ST_DONE) ? 1'b1 : 1'b0;
            end
            ST_ERROR: begin
                cfg_error_d = 1'b1;
            end
            default: begin
                byte_ready_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= {BCW{1'b0}};
            acc_q         <= 8'h00;
            shreg_q       <= 8'h00;
            byte_ready_q  <= 1'b0;
            chain_bit_q   <= 1'b0;
            chain_shift_q <= 1'b0;
            cfg_commit_q  <= 1'b0;
            cfg_done_q    <= 1'b0;
            cfg_error_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            acc_q         <= acc_d;
            shreg_q       <= shreg_d;
            byte_ready_q  <= byte_ready_d;
            chain_bit_q   <= chain_bit_d;
            chain_shift_q <= chain_shift_d;
            cfg_commit_q  <= cfg_commit_d;
            cfg_done_q    <= cfg_done_d;
            cfg_error_q   <= cfg_error_d;
            busy_q        <= busy_d;
        end
    end

    assign byte_ready  = byte_ready_q;
    assign chain_bit   = chain_bit_q;
    assign chain_shift = chain_shift_q;
    assign cfg_commit  = cfg_commit_q;
    assign cfg_done    = cfg_done_q;
    assign cfg_error   = cfg_error_q;
    assign busy        = busy_q;

endmodule

// File: doc/tiny_fpga_cfg_loader.md
# tiny_fpga_cfg_loader

Configuration loader sitting directly upstream of the tiny FPGA fabric inside `tt_um_tiny_fpga`. Accepts a framed configuration stream one byte at a time from the top-level pins (header, payload, XOR checksum). Serialises the payload LSB-first into the fabric's configuration shift chain. Issues a single commit pulse only when the frame verifies, so the fabric never latches a corrupt bitstream.

## Interface

Parameters:
- `CFG_BITS`, 64: configuration chain length in bits; must be a multiple of 8 and ≥ 8. `NBYTES = CFG_BITS/8`.
- `HEADER`, 8'hA5: required first byte of every frame.

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `cfg_mode`  input  1  1 = configuration session active; 0 = abort/idle.
- `byte_in`  input  8  stream byte.
- `byte_valid`  input  1  `byte_in` valid this cycle.
- `byte_ready`  output  1  loader can accept a byte this cycle.
- `chain_bit`  output  1  serial config data to the fabric chain.
- `chain_shift`  output  1  fabric shifts `chain_bit` in on this edge.
- `cfg_commit`  output  1  one-cycle pulse: chain contents are valid, latch into the fabric.
- `cfg_done`  output  1  level: last session succeeded.
- `cfg_error`  output  1  level: last session failed (bad header or checksum).
- `busy`  output  1  session in progress (states HDR, LOAD, SHIFT, CHK).

## Operation

- Byte transfer occurs on a rising edge where `byte_valid && byte_ready`. `byte_ready` depends only on state, never on `byte_valid`.
- States:
  - IDLE: `byte_ready=0`. Go to HDR when `cfg_mode=1`.
  - HDR: `byte_ready=1`. On transfer, go to LOAD if `byte_in==HEADER`, else ERROR. Reset byte counter and checksum accumulator to 0.
  - LOAD: `byte_ready=1`. On transfer, latch byte into an 8-bit shift register, XOR it into the accumulator, increment the byte counter, go to SHIFT with bit counter 0.
  - SHIFT: `byte_ready=0`, `chain_shift=1`, `chain_bit = shreg[0]`. Shift right each cycle. After the 8th bit: go to CHK if the byte counter equals `NBYTES`, else LOAD.
  - CHK: `byte_ready=1`. On transfer, go to DONE if `byte_in == accumulator`, else ERROR.
  - DONE: `cfg_done=1`; `cfg_commit=1` only on the first cycle in DONE. Stay while `cfg_mode=1`.
  - ERROR: `cfg_error=1`; no commit. Stay while `cfg_mode=1`.
- `cfg_mode=0` in any state: next state is IDLE and `chain_shift` is 0 from that next cycle. This includes mid-SHIFT; a partial byte is abandoned. `cfg_done`/`cfg_error` clear on entering IDLE.
- `chain_bit` is 0 whenever `chain_shift=0`.
- Counters:
  - bit counter: 3 bits, wraps 7→0.
  - byte counter: `$clog2(NBYTES+1)` bits, never wraps within a frame.
- A new session requires `cfg_mode` to drop to 0 for at least one cycle.

## Timing

- Reset values: state IDLE; `byte_ready`, `chain_bit`, `chain_shift`, `cfg_commit`, `cfg_done`, `cfg_error`, `busy` all 0; counters, accumulator and shift register all 0.
- Reset has priority over `cfg_mode` and any transfer. Reset mid-SHIFT yields `chain_shift=0` on the next cycle.
- Per payload byte: 1 accept cycle in LOAD plus 8 SHIFT cycles. Minimum 9 cycles per byte.
- The first `chain_shift` occurs the cycle after the LOAD transfer edge.
- Minimum frame length with back-to-back valid input: 1 (HDR) + 9·`NBYTES` + 1 (CHK) cycles.
- `cfg_commit` asserts the cycle after the CHK transfer edge, for exactly 1 cycle. `cfg_done` rises in that same cycle.
- `cfg_error` rises the cycle after the offending transfer edge.
- Idle gaps (`byte_valid=0` in HDR/LOAD/CHK) stall without timeout; state and counters hold.

## Test plan

- Reset: hold `rst=1` with `cfg_mode=1` and `byte_valid=1` → all outputs 0 throughout and 1 cycle after release; then `byte_ready=1` on the cycle after entering HDR.
- Good frame, `CFG_BITS=16`: send A5, 3C, 81, BD back-to-back. Required response:
  - `chain_shift` high for 16 cycles in two bursts of 8.
  - `chain_bit` sequence 0,0,1,1,1,1,0,0 then 1,0,0,0,0,0,0,1.
  - `cfg_commit` pulses once; `cfg_done=1`, `cfg_error=0`.
  - Total 20 cycles from HDR entry to `cfg_done`.
- Bad header: send 5A → `cfg_error=1` next cycle, no `chain_shift`, no commit; `byte_ready=0` thereafter.
- Bad checksum: A5, 3C, 81, BC → all 16 bits shift as above; then `cfg_error=1`, `cfg_commit` never asserts.
- Abort mid-shift: drop `cfg_mode` during the 4th shift cycle of byte 1 → `chain_shift=0` next cycle, `busy=0`, `cfg_done=cfg_error=0`. Re-raise `cfg_mode` and resend the good frame → normal success.
- Stalls: insert 5 idle cycles between each byte of the good frame → identical `chain_bit` sequence and a single commit.
